nrs_pingpong_buf: RTL and testbench

NRS_PINGPONG_BUF -- requirements
Module: nrs_pingpong_buf

---
 rtl/nrs_pingpong_buf_if.sv | 39 +++
 rtl/nrs_pingpong_buf.sv | 146 ++++++++++++++
 tb/tb_nrs_pingpong_buf.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/nrs_pingpong_buf_if.sv
// Bus bundle for the NRS ping-pong buffer: one write stream, bank handshake,
// and two independent read ports (estimator and fine timing).
interface nrs_pingpong_buf_if #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic              bank_rdy;
  logic [ADDR_W:0]   rd_len;
  logic              rd_done;
  logic              rd_en_est;
  logic [ADDR_W-1:0] rd_addr_est;
  logic [DATA_W-1:0] rd_data_est;
  logic              rd_vld_est;
  logic              rd_en_fine;
  logic [ADDR_W-1:0] rd_addr_fine;
  logic [DATA_W-1:0] rd_data_fine;
  logic              rd_vld_fine;
  logic              ovf_err;

  modport slave (
    input  wr_en, wr_data, wr_last, rd_done,
           rd_en_est, rd_addr_est, rd_en_fine, rd_addr_fine,
    output wr_ready, bank_rdy, rd_len, rd_data_est, rd_vld_est,
           rd_data_fine, rd_vld_fine, ovf_err
  );

  modport master (
    output wr_en, wr_data, wr_last, rd_done,
           rd_en_est, rd_addr_est, rd_en_fine, rd_addr_fine,
    input  wr_ready, bank_rdy, rd_len, rd_data_est, rd_vld_est,
           rd_data_fine, rd_vld_fine, ovf_err
  );
endinterface

// File: rtl/nrs_pingpong_buf.sv
// Double-buffered NRS symbol store: one bank fills while the other is read by
// two independent ports; a bank becomes readable only once its fill closes.
module nrs_pp_rd_port #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              bank_rdy,
  input  logic [ADDR_W:0]   rd_len,
  input  logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld
);
  logic              vld_d, vld_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    vld_d  = rd_en && bank_rdy;
    data_d = data_q;
    // Reads past the stored length return zero rather than stale bank contents.
    if (vld_d) data_d = ({1'b0, rd_addr} < rd_len) ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign rd_data = data_q;
  assign rd_vld  = vld_q;
endmodule

module nrs_pingpong_buf #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  nrs_pingpong_buf_if.slave   bus
);
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int NUM_LANES = 2;

  logic [DATA_W-1:0] bank_mem [2][DEPTH];

  logic              wr_sel_d, wr_sel_q;
  logic              rd_sel_d, rd_sel_q;
  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [1:0]        full_d, full_q;
  logic [1:0][ADDR_W:0] len_d, len_q;
  logic              ovf_d, ovf_q;

  logic wr_ready, bank_rdy, wr_acc, wr_close, rd_release;

  assign wr_ready   = !full_q[wr_sel_q];
  assign bank_rdy   = full_q[rd_sel_q];
  assign wr_acc     = bus.wr_en && wr_ready;
  assign wr_close   = wr_acc && (bus.wr_last || (wr_ptr_q == ADDR_W'(DEPTH - 1)));
  assign rd_release = bus.rd_done && bank_rdy;

  // Close and release may coincide; they always target different banks.
  always_comb begin
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_ptr_d = wr_ptr_q;
    full_d   = full_q;
    len_d    = len_q;
    ovf_d    = ovf_q || (bus.wr_en && !wr_ready);
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (wr_close) begin
      full_d[wr_sel_q] = 1'b1;
      len_d[wr_sel_q]  = {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
      wr_sel_d         = ~wr_sel_q;
      wr_ptr_d         = '0;
    end
    if (rd_release) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_ptr_q <= '0;
      full_q   <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) bank_mem[wr_sel_q][wr_ptr_q] <= bus.wr_data;
  end

  assign bus.wr_ready = wr_ready;
  assign bus.bank_rdy = bank_rdy;
  assign bus.rd_len   = bank_rdy ? len_q[rd_sel_q] : '0;
  assign bus.ovf_err  = ovf_q;

  // Lane 0 = estimator, lane 1 = fine timing.
  logic [NUM_LANES-1:0]             rd_en;
  logic [NUM_LANES-1:0][ADDR_W-1:0] rd_addr;
  wire  [NUM_LANES-1:0][DATA_W-1:0] rd_word;
  wire  [NUM_LANES-1:0][DATA_W-1:0] rd_data;
  wire  [NUM_LANES-1:0]             rd_vld;

  assign rd_en   = {bus.rd_en_fine, bus.rd_en_est};
  assign rd_addr = {bus.rd_addr_fine, bus.rd_addr_est};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign rd_word[g] = bank_mem[rd_sel_q][rd_addr[g]];
    nrs_pp_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en[g]),
      .rd_addr  (rd_addr[g]),
      .bank_rdy (bank_rdy),
      .rd_len   (bus.rd_len),
      .rd_word  (rd_word[g]),
      .rd_data  (rd_data[g]),
      .rd_vld   (rd_vld[g])
    );
  end

  assign bus.rd_data_est  = rd_data[0];
  assign bus.rd_vld_est   = rd_vld[0];
  assign bus.rd_data_fine = rd_data[1];
  assign bus.rd_vld_fine  = rd_vld[1];
endmodule

// File: tb/tb_nrs_pingpong_buf.sv
// Directed bench for nrs_pingpong_buf: flag checks inline, read data checked
// against per-port expected queues as each rd_vld appears.
module tb_nrs_pingpong_buf;
  localparam int DATA_W = 2;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nrs_pingpong_buf_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  nrs_pingpong_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [DATA_W-1:0] q_est[$];
  logic [DATA_W-1:0] q_fine[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d, input logic last);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.wr_last = last;
    step();
    bus.wr_en   = 1'b0;
    bus.wr_last = 1'b0;
  endtask

  task automatic rd_est(input logic [3:0] a, input logic [DATA_W-1:0] e);
    bus.rd_en_est = 1'b1; bus.rd_addr_est = a; q_est.push_back(e);
    step();
    bus.rd_en_est = 1'b0;
  endtask

  task automatic rd_fine(input logic [3:0] a, input logic [DATA_W-1:0] e);
    bus.rd_en_fine = 1'b1; bus.rd_addr_fine = a; q_fine.push_back(e);
    step();
    bus.rd_en_fine = 1'b0;
  endtask

  task automatic flags(input string tag, input logic wrdy, input logic brdy, input logic [4:0] len);
    chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'(wrdy));
    chk({tag, "_bank_rdy"}, 32'(bus.bank_rdy), 32'(brdy));
    chk({tag, "_rd_len"},   32'(bus.rd_len),   32'(len));
  endtask

  // Scoreboard: every rd_vld must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_vld_est) begin
        chk("est_vld_expected", 32'(q_est.size() > 0), 32'd1);
        if (q_est.size() > 0) chk("est_data", 32'(bus.rd_data_est), 32'(q_est.pop_front()));
      end
      if (bus.rd_vld_fine) begin
        chk("fine_vld_expected", 32'(q_fine.size() > 0), 32'd1);
        if (q_fine.size() > 0) chk("fine_data", 32'(bus.rd_data_fine), 32'(q_fine.pop_front()));
      end
    end
  end

  initial begin
    bus.wr_en = 0; bus.wr_data = 0; bus.wr_last = 0; bus.rd_done = 0;
    bus.rd_en_est = 0; bus.rd_addr_est = 0; bus.rd_en_fine = 0; bus.rd_addr_fine = 0;

    // Reset state
    rst = 1'b1; step(); step(); rst = 1'b0;
    flags("rst", 1, 0, 0);
    chk("rst_ovf", 32'(bus.ovf_err), 0);
    chk("rst_vld_est", 32'(bus.rd_vld_est), 0);
    chk("rst_vld_fine", 32'(bus.rd_vld_fine), 0);
    chk("rst_data_est", 32'(bus.rd_data_est), 0);

    // Full 16-entry fill closes on the last address
    for (int i = 0; i < DEPTH; i++) begin
      wr(DATA_W'(i % 4), 1'b0);
      if (i == DEPTH - 2) chk("partial_hidden", 32'(bus.bank_rdy), 0);
    end
    flags("fill16", 1, 1, 16);
    rd_est(4'd5, 2'd1);
    bus.rd_en_fine = 1'b1; bus.rd_addr_fine = 4'd15; q_fine.push_back(2'd3);
    rd_est(4'd15, 2'd3);
    bus.rd_en_fine = 1'b0;
    step();
    chk("hold_vld", 32'(bus.rd_vld_est), 0);
    chk("hold_data", 32'(bus.rd_data_est), 3);

    // Release bank 0; reads while nothing is ready produce no rd_vld
    bus.rd_done = 1'b1; step(); bus.rd_done = 1'b0;
    flags("rel0", 1, 0, 0);
    bus.rd_en_est = 1'b1; bus.rd_addr_est = 4'd0; step(); bus.rd_en_est = 1'b0;
    step();
    chk("norel_vld", 32'(bus.rd_vld_est), 0);
    chk("norel_hold", 32'(bus.rd_data_est), 3);

    // Short fill of 6 with wr_last into bank 1
    for (int i = 0; i < 6; i++) wr(DATA_W'((i + 1) % 4), i == 5);
    flags("fill6", 1, 1, 6);
    rd_fine(4'd7, 2'd0);
    rd_fine(4'd2, 2'd3);

    // Both banks full: next write dropped, sticky overflow
    for (int i = 0; i < DEPTH; i++) wr(DATA_W'(3 - (i % 4)), 1'b0);
    flags("both_full", 0, 1, 6);
    chk("ovf_before", 32'(bus.ovf_err), 0);
    wr(2'd1, 1'b1);
    flags("dropped", 0, 1, 6);
    chk("ovf_set", 32'(bus.ovf_err), 1);
    step();
    chk("ovf_sticky", 32'(bus.ovf_err), 1);
    rd_est(4'd0, 2'd1);

    // Release bank 1 -> bank 0 (16 entries, unaffected by dropped write)
    bus.rd_done = 1'b1; step(); bus.rd_done = 1'b0;
    flags("rel1", 1, 1, 16);
    rd_est(4'd0, 2'd3);
    rd_fine(4'd14, 2'd1);

    // Close of bank 1 coincides with release of bank 0
    wr(2'd2, 1'b0);
    wr(2'd1, 1'b0);
    bus.rd_done = 1'b1;
    wr(2'd3, 1'b1);
    bus.rd_done = 1'b0;
    flags("close_rel", 1, 1, 3);
    rd_est(4'd0, 2'd2);
    rd_fine(4'd1, 2'd1);
    rd_est(4'd2, 2'd3);

    // Both ports read address 3 across a release
    wr(2'd1, 0); wr(2'd1, 0); wr(2'd1, 0); wr(2'd2, 1);
    flags("fill4", 0, 1, 3);
    bus.rd_en_est = 1'b1; bus.rd_addr_est = 4'd3;
    bus.rd_en_fine = 1'b1; bus.rd_addr_fine = 4'd3;
    bus.rd_done = 1'b1; q_est.push_back(2'd0); q_fine.push_back(2'd0);
    step();
    bus.rd_done = 1'b0; q_est.push_back(2'd2); q_fine.push_back(2'd2);
    step();
    bus.rd_en_est = 1'b0; bus.rd_en_fine = 1'b0;
    flags("across_rel", 1, 1, 4);

    // Reset in the middle of a fill
    for (int i = 0; i < 9; i++) wr(2'd3, 1'b0);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    flags("midrst", 1, 0, 0);
    chk("midrst_ovf", 32'(bus.ovf_err), 0);
    wr(2'd3, 0); wr(2'd2, 0); wr(2'd1, 0); wr(2'd0, 1);
    flags("post_rst", 1, 1, 4);
    rd_est(4'd0, 2'd3);
    rd_fine(4'd5, 2'd0);
    rd_est(4'd3, 2'd0);

    step(); step();
    chk("est_q_drained", 32'(q_est.size()), 0);
    chk("fine_q_drained", 32'(q_fine.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
